// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer: FSM states, the
// registered output bundle, and the shared-counter width calculation.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RESET,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAULT
  } pll_seq_state_t;

  typedef struct packed {
    logic pll_rst;
    logic sys_rst;
    logic ready;
    logic fault;
  } pll_seq_outs_t;

  // One counter serves every timed state, so it is sized to the largest span.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

  function automatic pll_seq_outs_t state_outs(input pll_seq_state_t s);
    pll_seq_outs_t o;
    o.pll_rst = 1'b1;
    o.sys_rst = 1'b1;
    o.ready   = 1'b0;
    o.fault   = 1'b0;
    case (s)
      WAIT_LOCK, STABILIZE: o.pll_rst = 1'b0;
      RUN: begin
        o.pll_rst = 1'b0;
        o.sys_rst = 1'b0;
        o.ready   = 1'b1;
      end
      FAULT:   o.fault = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-stage synchronizer for asynchronous status inputs,
// cleared by a synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic srst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, qualifies its lock output and releases the system
// reset once lock has been stable; retries on timeout, faults after too many.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 2500000,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int RETRY_LIMIT        = 7
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] loss_count
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES, RETRY_LIMIT);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIM   = 4'(RETRY_LIMIT);

  pll_seq_state_t state_q;
  pll_seq_outs_t  outs_q;
  logic [CW-1:0]  cnt_q;
  logic [3:0]     retry_q;
  logic [7:0]     loss_q;
  logic [7:0]     loss_d;
  logic           lock_s;

  sync_2ff u_lock_sync (
    .clk  (clk25),
    .srst (rst),
    .d_i  (pll_lock),
    .q_o  (lock_s)
  );

  assign loss_d = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;

  // Outputs are loaded from the destination state on every transition so
  // they are plain flops that always agree with state_q.
  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q <= PLL_RESET;
      outs_q  <= state_outs(PLL_RESET);
      cnt_q   <= '0;
      retry_q <= 4'd0;
      loss_q  <= 8'd0;
    end else begin
      unique case (state_q)
        PLL_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_q <= WAIT_LOCK;
            outs_q  <= state_outs(WAIT_LOCK);
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= STABILIZE;
            outs_q  <= state_outs(STABILIZE);
            cnt_q   <= '0;
          end else if (cnt_q == TMO_LAST && retry_q == RETRY_LIM) begin
            state_q <= FAULT;
            outs_q  <= state_outs(FAULT);
          end else if (cnt_q == TMO_LAST) begin
            state_q <= PLL_RESET;
            outs_q  <= state_outs(PLL_RESET);
            cnt_q   <= '0;
            retry_q <= retry_q + 4'd1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        STABILIZE: begin
          // A dropout restarts the timeout without consuming a retry.
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            outs_q  <= state_outs(WAIT_LOCK);
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q <= RUN;
            outs_q  <= state_outs(RUN);
            retry_q <= 4'd0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_q <= PLL_RESET;
            outs_q  <= state_outs(PLL_RESET);
            cnt_q   <= '0;
            loss_q  <= loss_d;
          end
        end
        FAULT: begin
          if (restart) begin
            state_q <= PLL_RESET;
            outs_q  <= state_outs(PLL_RESET);
            cnt_q   <= '0;
            retry_q <= 4'd0;
          end
        end
        default: begin
          state_q <= PLL_RESET;
          outs_q  <= state_outs(PLL_RESET);
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign pll_rst     = outs_q.pll_rst;
  assign sys_rst     = outs_q.sys_rst;
  assign ready       = outs_q.ready;
  assign fault       = outs_q.fault;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters;
// expected edge counts are worked out by hand from the sequencing rules.
module tb_pll_reset_sequencer;

  localparam int RST_N   = 4;
  localparam int TMO_N   = 32;
  localparam int STAB_N  = 8;
  localparam int RETRIES = 2;
  // Edges counted from e0 (inclusive) until ready is seen: e0 + 2 + STAB_N.
  localparam int LOCK_TO_READY = 1 + 2 + STAB_N;

  logic       clk25;
  logic       rst;
  logic       pll_lock;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] loss_count;

  int checks;
  int errors;
  int n;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES     (RST_N),
    .LOCK_TIMEOUT       (TMO_N),
    .LOCK_STABLE_CYCLES (STAB_N),
    .RETRY_LIMIT        (RETRIES)
  ) dut (
    .clk25       (clk25),
    .rst         (rst),
    .pll_lock    (pll_lock),
    .restart     (restart),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .fault       (fault),
    .retry_count (retry_count),
    .loss_count  (loss_count)
  );

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!ready && cnt < 400);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_pll_rst"}, 32'(pll_rst), 1);
    chk({tag, "_sys_rst"}, 32'(sys_rst), 1);
    chk({tag, "_ready"}, 32'(ready), 0);
    chk({tag, "_fault"}, 32'(fault), 0);
    chk({tag, "_retry"}, 32'(retry_count), 0);
    chk({tag, "_loss"}, 32'(loss_count), 0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    pll_lock = 1'b0;
    restart  = 1'b0;
    tick();
    tick();
    chk_reset_outs("reset");

    // Nominal bring-up: pll_rst high for the release cycle plus three edges.
    rst = 1'b0;
    for (int i = 1; i < RST_N; i++) begin
      tick();
      chk("nom_pll_rst_hi", 32'(pll_rst), 1);
    end
    tick();
    chk("nom_pll_rst_lo", 32'(pll_rst), 0);
    for (int i = 0; i < 6; i++) tick();
    pll_lock = 1'b1;
    wait_ready(n);
    chk("nom_lock_to_ready", n, LOCK_TO_READY);
    chk("nom_sys_rst", 32'(sys_rst), 0);
    chk("nom_retry", 32'(retry_count), 0);

    // One-cycle lock glitch while stabilising restarts the stable count.
    rst = 1'b1;
    pll_lock = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    pll_lock = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("glitch_in_stab", 32'(sys_rst), 1);
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    wait_ready(n);
    chk("glitch_lock_to_ready", n, LOCK_TO_READY);
    chk("glitch_retry", 32'(retry_count), 0);

    // Timeout: WAIT_LOCK entered after edge 4, times out on edge 36.
    rst = 1'b1;
    pll_lock = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 35; i++) tick();
    chk("tmo_retry_before", 32'(retry_count), 0);
    chk("tmo_pll_rst_before", 32'(pll_rst), 0);
    tick();
    chk("tmo_retry_after", 32'(retry_count), 1);
    chk("tmo_pll_rst_pulse", 32'(pll_rst), 1);
    for (int i = 1; i < RST_N; i++) begin
      tick();
      chk("tmo_pll_rst_hi", 32'(pll_rst), 1);
    end
    tick();
    chk("tmo_pll_rst_lo", 32'(pll_rst), 0);
    pll_lock = 1'b1;
    wait_ready(n);
    chk("tmo_lock_to_ready", n, LOCK_TO_READY);
    chk("tmo_retry_cleared", 32'(retry_count), 0);

    // Fault: 4 initial reset cycles + 3*32 waits + 2*4 retry resets = 108 edges.
    rst = 1'b1;
    pll_lock = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 107; i++) tick();
    chk("fault_early", 32'(fault), 0);
    tick();
    chk("fault_set", 32'(fault), 1);
    chk("fault_pll_rst", 32'(pll_rst), 1);
    chk("fault_sys_rst", 32'(sys_rst), 1);
    chk("fault_retry", 32'(retry_count), RETRIES);
    pll_lock = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("fault_held", 32'(fault), 1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_fault_clr", 32'(fault), 0);
    chk("restart_retry_clr", 32'(retry_count), 0);
    chk("restart_pll_rst", 32'(pll_rst), 1);
    // Restart edge R: WAIT at R+4, STABILIZE at R+5, RUN at R+13.
    wait_ready(n);
    chk("restart_to_ready", n, 13);

    // Loss of lock in RUN: sys_rst back on the third edge.
    pll_lock = 1'b0;
    tick();
    chk("loss_e1_sys_rst", 32'(sys_rst), 0);
    tick();
    chk("loss_e2_sys_rst", 32'(sys_rst), 0);
    tick();
    chk("loss_e3_sys_rst", 32'(sys_rst), 1);
    chk("loss_count_1", 32'(loss_count), 1);
    chk("loss_pll_rst", 32'(pll_rst), 1);
    for (int i = 1; i < RST_N; i++) begin
      tick();
      chk("loss_pll_rst_hi", 32'(pll_rst), 1);
    end
    tick();
    chk("loss_pll_rst_lo", 32'(pll_rst), 0);
    pll_lock = 1'b1;
    wait_ready(n);
    chk("loss_recover", 32'(ready), 1);

    // 299 further losses for 300 total; count saturates.
    for (int k = 0; k < 299; k++) begin
      pll_lock = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      pll_lock = 1'b1;
      wait_ready(n);
    end
    chk("loss_saturate", 32'(loss_count), 255);
    chk("loss_final_ready", 32'(ready), 1);

    // Reset while in RUN.
    rst = 1'b1;
    tick();
    chk_reset_outs("rst_run");

    // Reset while in STABILIZE after a retry, so retry_count is nonzero.
    rst = 1'b0;
    pll_lock = 1'b0;
    for (int i = 0; i < 37; i++) tick();
    chk("stab_pre_retry", 32'(retry_count), 1);
    pll_lock = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("stab_pre_ready", 32'(ready), 0);
    rst = 1'b1;
    tick();
    chk_reset_outs("rst_stab");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
